dout_decimator: RTL and testbench

Two-channel boxcar averager and decimator that sits directly downstream of the AD7771 DOUT reader. It consumes the reader's 24-bit two's-complement channel words and update tick. It sums 2^LOG2_N consecutive samples per channel and emits the floor-mean of each block at the reduced rate. The result is held behind a valid/ready output handshake, with a sticky overrun flag, for the logging/transmit path.

---
 rtl/dout_decimator.sv | 94 +++++++++
 tb/tb_dout_decimator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dout_decimator.sv
// rtl/dout_decimator.sv - two-channel boxcar averager/decimator with valid/ready output and sticky overrun
module dout_decimator #(
    parameter int LOG2_N = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [23:0] ch1_i,
    input  logic [23:0] ch2_i,
    input  logic        tick_i,
    output logic [23:0] ch1_o,
    output logic [23:0] ch2_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        overrun_o,
    input  logic        overrun_clr_i
);

    localparam int AW = 24 + LOG2_N;
    // LOG2_N=0 keeps a 1-bit counter that never leaves zero, so every tick completes a block
    localparam int CW = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
    logic [23:0]          ch1_q, ch1_d, ch2_q, ch2_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic                 block_done;
    logic signed [AW-1:0] sum1, sum2, mean1, mean2;

    always_comb begin
        block_done = tick_i && (cnt_q == CNT_LAST);
        sum1       = acc1_q + AW'($signed(ch1_i));
        sum2       = acc2_q + AW'($signed(ch2_i));
        mean1      = sum1 >>> LOG2_N;
        mean2      = sum2 >>> LOG2_N;

        cnt_d      = cnt_q;
        acc1_d     = acc1_q;
        acc2_d     = acc2_q;
        ch1_d      = ch1_q;
        ch2_d      = ch2_q;

        if (block_done) begin
            cnt_d  = '0;
            acc1_d = '0;
            acc2_d = '0;
            ch1_d  = mean1[23:0];
            ch2_d  = mean2[23:0];
        end else if (tick_i) begin
            cnt_d  = cnt_q + 1'b1;
            acc1_d = sum1;
            acc2_d = sum2;
        end

        // a load keeps valid high even when the old result transfers in the same cycle
        valid_d = block_done | (valid_q & ~ready_i);

        // set has priority over clear
        if (block_done && valid_q && !ready_i)
            overrun_d = 1'b1;
        else if (overrun_clr_i)
            overrun_d = 1'b0;
        else
            overrun_d = overrun_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            acc1_q    <= '0;
            acc2_q    <= '0;
            ch1_q     <= '0;
            ch2_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            ch1_q     <= ch1_d;
            ch2_q     <= ch2_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign ch1_o     = ch1_q;
    assign ch2_o     = ch2_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_dout_decimator.sv
// tb/tb_dout_decimator.sv - directed-vector bench for dout_decimator at LOG2_N = 0, 1, 2
module tb_dout_decimator;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [23:0] ch1_i = '0;
    logic [23:0] ch2_i = '0;
    logic        tick_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        overrun_clr_i = 1'b0;

    logic [23:0] a_ch1, a_ch2, b_ch1, b_ch2, c_ch1, c_ch2;
    logic        a_valid, a_ovr, b_valid, b_ovr, c_valid, c_ovr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dout_decimator #(.LOG2_N(2)) u_n4 (
        .clk_i(clk), .reset_i(reset_i), .ch1_i(ch1_i), .ch2_i(ch2_i), .tick_i(tick_i),
        .ch1_o(a_ch1), .ch2_o(a_ch2), .valid_o(a_valid), .ready_i(ready_i),
        .overrun_o(a_ovr), .overrun_clr_i(overrun_clr_i)
    );

    dout_decimator #(.LOG2_N(1)) u_n2 (
        .clk_i(clk), .reset_i(reset_i), .ch1_i(ch1_i), .ch2_i(ch2_i), .tick_i(tick_i),
        .ch1_o(b_ch1), .ch2_o(b_ch2), .valid_o(b_valid), .ready_i(ready_i),
        .overrun_o(b_ovr), .overrun_clr_i(overrun_clr_i)
    );

    dout_decimator #(.LOG2_N(0)) u_n1 (
        .clk_i(clk), .reset_i(reset_i), .ch1_i(ch1_i), .ch2_i(ch2_i), .tick_i(tick_i),
        .ch1_o(c_ch1), .ch2_o(c_ch2), .valid_o(c_valid), .ready_i(ready_i),
        .overrun_o(c_ovr), .overrun_clr_i(overrun_clr_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drive one cycle's inputs, let the edge happen, sample 1 ns after it
    task automatic step(input logic t, input logic [23:0] c1, input logic [23:0] c2);
        tick_i = t;
        ch1_i  = c1;
        ch2_i  = c2;
        @(posedge clk);
        #1;
        tick_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step(1'b0, 24'h0, 24'h0);
        reset_i = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        check("rst_ch1", {8'h0, a_ch1}, 32'h0);
        check("rst_ch2", {8'h0, a_ch2}, 32'h0);
        check("rst_valid", {31'h0, a_valid}, 32'h0);
        check("rst_ovr", {31'h0, a_ovr}, 32'h0);

        // mean of 4,8,12,16 and constant 0x100, ready held high
        ready_i = 1'b1;
        step(1'b1, 24'd4, 24'h100);
        step(1'b1, 24'd8, 24'h100);
        step(1'b1, 24'd12, 24'h100);
        check("mean_early_valid", {31'h0, a_valid}, 32'h0);
        step(1'b1, 24'd16, 24'h100);
        check("mean_ch1", {8'h0, a_ch1}, 32'h00000A);
        check("mean_ch2", {8'h0, a_ch2}, 32'h000100);
        check("mean_valid", {31'h0, a_valid}, 32'h1);
        step(1'b0, 24'h0, 24'h0);
        check("mean_valid_drop", {31'h0, a_valid}, 32'h0);

        // floor rounding and full-scale extremes
        step(1'b1, 24'hFFFFFF, 24'h7FFFFF);
        step(1'b1, 24'hFFFFFF, 24'h7FFFFF);
        step(1'b1, 24'hFFFFFF, 24'h7FFFFF);
        step(1'b1, 24'hFFFFFE, 24'h7FFFFF);
        check("floor_ch1", {8'h0, a_ch1}, 32'hFFFFFE);
        check("max_ch2", {8'h0, a_ch2}, 32'h7FFFFF);
        for (int i = 0; i < 4; i++) step(1'b1, 24'h0, 24'h800000);
        check("min_ch2", {8'h0, a_ch2}, 32'h800000);
        check("min_ch1", {8'h0, a_ch1}, 32'h0);
        check("min_ovr", {31'h0, a_ovr}, 32'h0);

        // backpressure and overrun at N=2
        do_reset();
        ready_i = 1'b0;
        step(1'b1, 24'd2, 24'd0);
        step(1'b1, 24'd4, 24'd0);
        check("bp_ch1_a", {8'h0, b_ch1}, 32'd3);
        check("bp_valid_a", {31'h0, b_valid}, 32'h1);
        check("bp_ovr_a", {31'h0, b_ovr}, 32'h0);
        step(1'b1, 24'd6, 24'd0);
        step(1'b1, 24'd8, 24'd0);
        check("bp_ch1_b", {8'h0, b_ch1}, 32'd7);
        check("bp_ovr_b", {31'h0, b_ovr}, 32'h1);
        check("bp_valid_b", {31'h0, b_valid}, 32'h1);
        ready_i = 1'b1;
        step(1'b0, 24'd0, 24'd0);
        ready_i = 1'b0;
        check("bp_valid_xfer", {31'h0, b_valid}, 32'h0);
        check("bp_ovr_sticky", {31'h0, b_ovr}, 32'h1);
        overrun_clr_i = 1'b1;
        step(1'b0, 24'd0, 24'd0);
        overrun_clr_i = 1'b0;
        check("bp_ovr_clr", {31'h0, b_ovr}, 32'h0);

        // clear and set in the same cycle: set wins
        step(1'b1, 24'd10, 24'd0);
        step(1'b1, 24'd12, 24'd0);
        check("sw_ch1_a", {8'h0, b_ch1}, 32'd11);
        step(1'b1, 24'd14, 24'd0);
        overrun_clr_i = 1'b1;
        step(1'b1, 24'd16, 24'd0);
        overrun_clr_i = 1'b0;
        check("sw_ch1_b", {8'h0, b_ch1}, 32'd15);
        check("sw_ovr", {31'h0, b_ovr}, 32'h1);

        // pass-through at N=1 with transfer coincident with each load
        do_reset();
        ready_i = 1'b1;
        step(1'b1, 24'd1, 24'd0);
        check("pt_ch1_1", {8'h0, c_ch1}, 32'd1);
        check("pt_valid_1", {31'h0, c_valid}, 32'h1);
        step(1'b1, 24'd2, 24'd0);
        check("pt_ch1_2", {8'h0, c_ch1}, 32'd2);
        check("pt_valid_2", {31'h0, c_valid}, 32'h1);
        step(1'b1, 24'd3, 24'd0);
        check("pt_ch1_3", {8'h0, c_ch1}, 32'd3);
        check("pt_valid_3", {31'h0, c_valid}, 32'h1);
        check("pt_ovr", {31'h0, c_ovr}, 32'h0);
        step(1'b0, 24'd0, 24'd0);
        check("pt_valid_drop", {31'h0, c_valid}, 32'h0);

        // reset mid-block discards partial sums
        do_reset();
        step(1'b1, 24'd100, 24'd0);
        step(1'b1, 24'd100, 24'd0);
        reset_i = 1'b1;
        step(1'b1, 24'd100, 24'd0);
        reset_i = 1'b0;
        check("mr_valid_rst", {31'h0, a_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 24'd1, 24'd0);
            check("mr_valid_early", {31'h0, a_valid}, 32'h0);
        end
        step(1'b1, 24'd1, 24'd0);
        check("mr_ch1", {8'h0, a_ch1}, 32'd1);
        check("mr_valid", {31'h0, a_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
